// File: rtl/key_pkg.sv
// key_pkg: shared widths, scan state encoding and key byte extraction for key_match
package key_pkg;
    localparam int KEY_W = 8;
    localparam int MAXK = 4;
    localparam int KEYS_W = KEY_W * MAXK;

    typedef enum logic [1:0] {IDLE, FILL, SCAN} state_t;

    function automatic logic [KEY_W-1:0] key_byte(input logic [KEYS_W-1:0] keys, input int i);
        return keys[i*KEY_W +: KEY_W];
    endfunction
endpackage

// File: rtl/key_window.sv
// key_window: newest-first byte history with a saturating fill count
module key_window
    import key_pkg::*;
(
    input  logic                        dclk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        shift,
    input  logic [KEY_W-1:0]            din,
    output logic [MAXK-1:0][KEY_W-1:0]  hist_nxt,
    output logic [2:0]                  fill_nxt
);
    logic [MAXK-1:0][KEY_W-1:0] hist;
    logic [2:0]                 fill;

    // Next-state values are exported so the matcher can compare against the updated window
    always_comb begin
        hist_nxt = clr ? '0 : shift ? {hist[MAXK-2:0], din} : hist;
        fill_nxt = clr ? 3'd0 : (shift && fill != 3'(MAXK)) ? fill + 3'd1 : fill;
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end
endmodule

// File: rtl/key_match.sv
// key_match: snapshots the stored key sequence on arm and flags each occurrence in the byte stream
module key_match
    import key_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              dclk,
    input  logic              reset,
    input  logic              arm,
    input  logic              disarm,
    input  logic              clr_cnt,
    input  logic [KEY_W-1:0]  din,
    input  logic              dvalid,
    input  logic [2:0]        num_keys,
    input  logic [KEYS_W-1:0] keys,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              armed,
    output logic              cfg_err
);
    state_t                     state;
    logic [KEYS_W-1:0]          pat;
    logic [2:0]                 n;
    logic [MAXK-1:0][KEY_W-1:0] hist_nxt;
    logic [2:0]                 fill_nxt;
    logic                       shift, cfg_ok, eq, hit;

    assign shift  = dvalid && state != IDLE;
    assign cfg_ok = num_keys != 3'd0 && num_keys <= 3'(MAXK);

    key_window u_window (
        .dclk     (dclk),
        .reset    (reset),
        .clr      (arm),
        .shift    (shift),
        .din      (din),
        .hist_nxt (hist_nxt),
        .fill_nxt (fill_nxt)
    );

    // Key byte i lines up with the byte captured n-1-i positions before the newest one
    always_comb begin
        eq = 1'b1;
        for (int i = 0; i < MAXK; i++)
            if (3'(i) < n && hist_nxt[2'(n - 3'(i) - 3'd1)] != key_byte(pat, i)) eq = 1'b0;
    end

    assign hit = shift && !arm && !disarm && fill_nxt >= n && eq;

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pat         <= '0;
            n           <= '0;
            match       <= 1'b0;
            match_count <= '0;
            armed       <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            match       <= hit;
            match_count <= clr_cnt ? '0 : (hit && !(&match_count)) ? match_count + CNT_W'(1) : match_count;
            if (disarm) begin
                state <= IDLE;
                armed <= 1'b0;
            end else if (arm && cfg_ok) begin
                pat   <= keys;
                n     <= num_keys;
                state <= FILL;
                armed <= 1'b1;
            end else if (arm) begin
                cfg_err <= 1'b1;
                state   <= IDLE;
                armed   <= 1'b0;
            end else if (state == FILL && shift && fill_nxt >= n) begin
                state <= SCAN;
            end
        end
    end
endmodule

// File: tb/tb_key_match.sv
// tb_key_match: scoreboard bench for key_match driven by an independent queue-based reference model
module tb_key_match;
    logic        dclk = 1'b0, reset = 1'b1, arm = 1'b0, disarm = 1'b0, clr_cnt = 1'b0, dvalid = 1'b0;
    logic [7:0]  din = '0;
    logic [2:0]  num_keys = '0;
    logic [31:0] keys = '0;
    logic        match, armed, cfg_err, match4, armed4, cfg_err4;
    logic [15:0] match_count;
    logic [3:0]  match_count4;

    key_match #(.CNT_W(16)) dut (
        .dclk(dclk), .reset(reset), .arm(arm), .disarm(disarm), .clr_cnt(clr_cnt),
        .din(din), .dvalid(dvalid), .num_keys(num_keys), .keys(keys),
        .match(match), .match_count(match_count), .armed(armed), .cfg_err(cfg_err)
    );

    key_match #(.CNT_W(4)) u_sat (
        .dclk(dclk), .reset(reset), .arm(arm), .disarm(disarm), .clr_cnt(clr_cnt),
        .din(din), .dvalid(dvalid), .num_keys(num_keys), .keys(keys),
        .match(match4), .match_count(match_count4), .armed(armed4), .cfg_err(cfg_err4)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        bit m;
        int cnt;
        int cnt4;
        bit arm;
        bit err;
    } exp_t;

    exp_t        exp_q[$];
    int          hq[$];
    bit          m_armed, m_err;
    logic [31:0] m_pat;
    int          m_n, m_cnt, m_cnt4;
    int          n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_err = 0; m_pat = '0; m_n = 0; m_cnt = 0; m_cnt4 = 0;
        hq.delete();
        exp_q.delete();
    endtask

    task automatic step(input bit a, input bit d, input bit c, input bit v, input logic [7:0] b);
        exp_t e;
        bit   hit;
        arm = a; disarm = d; clr_cnt = c; dvalid = v; din = b;
        hit = 0;
        if (d) m_armed = 0;
        else if (a) begin
            if (num_keys >= 1 && num_keys <= 4) begin
                m_armed = 1; m_pat = keys; m_n = int'(num_keys); hq.delete();
            end else begin
                m_err = 1; m_armed = 0;
            end
        end else if (m_armed && v) begin
            hq.push_back(int'(b));
            if (hq.size() > 4) void'(hq.pop_front());
            if (hq.size() >= m_n) begin
                hit = 1;
                for (int i = 0; i < m_n; i++)
                    if (hq[hq.size() - m_n + i] != int'(m_pat[8*i +: 8])) hit = 0;
            end
        end
        if (c) begin
            m_cnt = 0; m_cnt4 = 0;
        end else if (hit) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        exp_q.push_back('{m: hit, cnt: m_cnt, cnt4: m_cnt4, arm: m_armed, err: m_err});
        @(posedge dclk);
        #1;
        arm = 0; disarm = 0; clr_cnt = 0; dvalid = 0;
        e = exp_q.pop_front();
        check("match", match, e.m);
        check("match_count", match_count, e.cnt);
        check("armed", armed, e.arm);
        check("cfg_err", cfg_err, e.err);
        check("match4", match4, e.m);
        check("match_count4", match_count4, e.cnt4);
    endtask

    task automatic do_reset();
        @(negedge dclk);
        reset = 1;
        model_reset();
        #2 reset = 0;
    endtask

    task automatic stream(input logic [7:0] b);
        step(0, 0, 0, 1, b);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge dclk);
        #1;
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_armed", armed, 0);
        check("rst_cfg_err", cfg_err, 0);
        @(negedge dclk) reset = 0;

        // full-length hit
        keys = 32'h1E0E0602; num_keys = 3'd4;
        step(1, 0, 0, 0, 8'h00);
        stream(8'h02); stream(8'h06); stream(8'h0E);
        check("t1_pre_match", match, 0);
        stream(8'h1E);
        check("t1_match", match, 1);
        check("t1_count", match_count, 1);
        check("t1_armed", armed, 1);
        stream(8'h02);
        check("t1_pulse_end", match, 0);

        // overlapping two-byte pattern with an idle gap
        keys = 32'h00000202; num_keys = 3'd2;
        step(1, 0, 0, 1, 8'h02);
        stream(8'h02);
        step(0, 0, 0, 0, 8'h02);
        stream(8'h02);
        stream(8'h02);
        check("t2_count", match_count, 3);

        // pre-arm bytes and snapshot isolation
        do_reset();
        keys = 32'h00000602; num_keys = 3'd2;
        stream(8'h02); stream(8'h06);
        step(1, 0, 0, 0, 8'h00);
        keys = 32'hFFFFFFFF; num_keys = 3'd4;
        stream(8'h0E); stream(8'h02); stream(8'h06);
        check("t3_count", match_count, 1);

        // configuration errors
        num_keys = 3'd0;
        step(1, 0, 0, 0, 8'h00);
        check("t4_cfg_err", cfg_err, 1);
        check("t4_armed", armed, 0);
        stream(8'hFF); stream(8'hFF);
        num_keys = 3'd5;
        step(1, 0, 0, 0, 8'h00);
        check("t4_cfg_err_sticky", cfg_err, 1);

        // clear and disarm racing a completing byte
        keys = 32'h00000602; num_keys = 3'd2;
        step(1, 0, 0, 0, 8'h00);
        stream(8'h02);
        step(0, 0, 1, 1, 8'h06);
        check("t5_clr_match", match, 1);
        check("t5_clr_count", match_count, 0);
        stream(8'h02);
        step(0, 1, 0, 1, 8'h06);
        check("t5_disarm_match", match, 0);
        check("t5_disarm_armed", armed, 0);
        step(1, 1, 0, 1, 8'h02);
        check("t5_disarm_wins", armed, 0);

        // re-arm mid-scan, then async reset during FILL
        keys = 32'h00000202; num_keys = 3'd2;
        step(1, 0, 0, 0, 8'h00);
        stream(8'h02); stream(8'h02);
        keys = 32'h1E0E0602; num_keys = 3'd4;
        step(1, 0, 0, 1, 8'h02);
        stream(8'h02);
        check("t6_pre_armed", armed, 1);
        #2 reset = 1;
        #1;
        check("t6_async_match", match, 0);
        check("t6_async_count", match_count, 0);
        check("t6_async_armed", armed, 0);
        check("t6_async_cfg_err", cfg_err, 0);
        model_reset();
        @(negedge dclk) reset = 0;
        stream(8'h06); stream(8'h0E); stream(8'h1E);

        // saturation on the narrow counter
        keys = 32'h000000AA; num_keys = 3'd1;
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) stream(8'hAA);
        check("t7_sat_count4", match_count4, 15);
        check("t7_wide_count", match_count, 20);
        check("t7_still_pulsing", match4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
